// File: rtl/cpu_datapath_pkg.sv
// rtl/cpu_datapath_pkg.sv - shared widths and ALU opcodes for the datapath
package cpu_datapath_pkg;

  localparam int DATA_W = 32;
  localparam int WIDE_W = 64;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_SHR  = 5'b01001,
    OP_SHRA = 5'b01010,
    OP_SHL  = 5'b01011,
    OP_DIV  = 5'b01111,
    OP_MUL  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU, A from Y and B from the bus
module alu import cpu_datapath_pkg::*; (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [4:0]        i_opcode,
  input  logic              i_inc,
  output logic [WIDE_W-1:0] o_result
);

  logic [4:0]               w_sh;
  logic [WIDE_W-1:0]        w_dbl;
  logic [WIDE_W-1:0]        w_ror;
  logic [WIDE_W-1:0]        w_rol;
  logic [WIDE_W-1:0]        w_prod;
  logic [DATA_W-1:0]        w_inc;
  logic signed [DATA_W-1:0] w_quot;
  logic signed [DATA_W-1:0] w_rem;

  assign w_sh   = i_b[4:0];
  // Rotates shift a doubled copy of A so no separate wrap logic is needed.
  assign w_dbl  = {i_a, i_a};
  assign w_ror  = w_dbl >> w_sh;
  assign w_rol  = w_dbl << w_sh;
  assign w_prod = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) *
                  $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
  assign w_inc  = i_b + 32'd1;

  always_comb begin
    w_quot = '0;
    w_rem  = $signed(i_a);
    if (i_b == '0) begin
      w_quot = '0;
    end else if (i_a == {1'b1, {(DATA_W-1){1'b0}}} && i_b == '1) begin
      w_quot = $signed(i_a);
      w_rem  = '0;
    end else begin
      w_quot = $signed(i_a) / $signed(i_b);
      w_rem  = $signed(i_a) % $signed(i_b);
    end
  end

  always_comb begin
    o_result = '0;
    if (i_inc) begin
      o_result = {{DATA_W{1'b0}}, w_inc};
    end else begin
      case (i_opcode)
        OP_ADD:  o_result[DATA_W-1:0] = i_a + i_b;
        OP_SUB:  o_result[DATA_W-1:0] = i_a - i_b;
        OP_AND:  o_result[DATA_W-1:0] = i_a & i_b;
        OP_OR:   o_result[DATA_W-1:0] = i_a | i_b;
        OP_ROR:  o_result[DATA_W-1:0] = w_ror[DATA_W-1:0];
        OP_ROL:  o_result[DATA_W-1:0] = w_rol[WIDE_W-1:DATA_W];
        OP_SHR:  o_result[DATA_W-1:0] = i_a >> w_sh;
        OP_SHRA: o_result[DATA_W-1:0] = $signed(i_a) >>> w_sh;
        OP_SHL:  o_result[DATA_W-1:0] = i_a << w_sh;
        OP_DIV:  o_result = {w_rem, w_quot};
        OP_MUL:  o_result = w_prod;
        OP_NEG:  o_result[DATA_W-1:0] = 32'd0 - i_b;
        OP_NOT:  o_result[DATA_W-1:0] = ~i_b;
        default: o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/reg32.sv
// rtl/reg32.sv - enable register with synchronous clear
// Defaults to 32 bits; Z reuses it at 64 bits.
module reg32 import cpu_datapath_pkg::*; #(
  parameter int W = DATA_W
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_clr)     r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - bus-based 32-bit datapath top
// Register file, special registers, bus mux and ALU; sequencing lives outside.
module cpu_datapath import cpu_datapath_pkg::*; (
  input  logic              clk,
  input  logic              clr,
  input  logic              R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic              R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic              R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic              R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic              HIin, LOin, HIout, LOout,
  input  logic              Zin, Zhighout, Zlowout,
  input  logic              PCin, PCout, incPC,
  input  logic              IRin, MARin, MDRin, MDRout, Read,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic              InPortin, InPortout,
  input  logic [DATA_W-1:0] InPort_data,
  input  logic              Cin, Cout, Yin,
  input  logic [4:0]        opcode,
  output logic [DATA_W-1:0] BusMuxOut,
  output logic [WIDE_W-1:0] Zq,
  output logic [DATA_W-1:0] HIq, LOq, PCq, IRq, MARq
);

  logic [15:0]       w_rin;
  logic [15:0]       w_rout;
  logic [DATA_W-1:0] w_rq [16];
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W-1:0] w_mdr_d, w_mdrq, w_yq, w_inq, w_cq;
  logic [WIDE_W-1:0] w_alu_res;

  assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  for (genvar g = 0; g < 16; g++) begin : g_rf
    reg32 u_r (.i_clk(clk), .i_clr(clr), .i_en(w_rin[g]), .i_d(w_bus), .o_q(w_rq[g]));
  end

  assign w_mdr_d = Read ? Mdatain : w_bus;

  reg32 u_pc   (.i_clk(clk), .i_clr(clr), .i_en(PCin),     .i_d(w_bus),       .o_q(PCq));
  reg32 u_ir   (.i_clk(clk), .i_clr(clr), .i_en(IRin),     .i_d(w_bus),       .o_q(IRq));
  reg32 u_mar  (.i_clk(clk), .i_clr(clr), .i_en(MARin),    .i_d(w_bus),       .o_q(MARq));
  reg32 u_mdr  (.i_clk(clk), .i_clr(clr), .i_en(MDRin),    .i_d(w_mdr_d),     .o_q(w_mdrq));
  reg32 u_y    (.i_clk(clk), .i_clr(clr), .i_en(Yin),      .i_d(w_bus),       .o_q(w_yq));
  reg32 u_hi   (.i_clk(clk), .i_clr(clr), .i_en(HIin),     .i_d(w_bus),       .o_q(HIq));
  reg32 u_lo   (.i_clk(clk), .i_clr(clr), .i_en(LOin),     .i_d(w_bus),       .o_q(LOq));
  reg32 u_in   (.i_clk(clk), .i_clr(clr), .i_en(InPortin), .i_d(InPort_data), .o_q(w_inq));
  reg32 u_c    (.i_clk(clk), .i_clr(clr), .i_en(Cin),      .i_d(w_bus),       .o_q(w_cq));
  reg32 #(.W(WIDE_W)) u_z (.i_clk(clk), .i_clr(clr), .i_en(Zin), .i_d(w_alu_res), .o_q(Zq));

  alu u_alu (.i_a(w_yq), .i_b(w_bus), .i_opcode(opcode), .i_inc(incPC), .o_result(w_alu_res));

  // Lowest-priority source first; each later match overrides, so R0 ends up on top.
  always_comb begin
    w_bus = '0;
    if (Cout)      w_bus = w_cq;
    if (InPortout) w_bus = w_inq;
    if (MDRout)    w_bus = w_mdrq;
    if (PCout)     w_bus = PCq;
    if (Zlowout)   w_bus = Zq[DATA_W-1:0];
    if (Zhighout)  w_bus = Zq[WIDE_W-1:DATA_W];
    if (LOout)     w_bus = LOq;
    if (HIout)     w_bus = HIq;
    for (int i = 15; i >= 0; i--) begin
      if (w_rout[i]) w_bus = w_rq[i];
    end
  end

  assign BusMuxOut = w_bus;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - scoreboard bench for cpu_datapath
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] r_in, r_out;
  logic        HIin, LOin, HIout, LOout, Zin, Zhighout, Zlowout;
  logic        PCin, PCout, incPC, IRin, MARin, MDRin, MDRout, Read;
  logic [31:0] Mdatain, InPort_data;
  logic        InPortin, InPortout, Cin, Cout, Yin;
  logic [4:0]  opcode;
  logic [31:0] BusMuxOut, HIq, LOq, PCq, IRq, MARq;
  logic [63:0] Zq;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  typedef struct {
    string       tag;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .clr(clr),
    .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
    .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
    .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
    .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
    .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCin(PCin), .PCout(PCout), .incPC(incPC),
    .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read),
    .Mdatain(Mdatain), .InPortin(InPortin), .InPortout(InPortout),
    .InPort_data(InPort_data), .Cin(Cin), .Cout(Cout), .Yin(Yin),
    .opcode(opcode), .BusMuxOut(BusMuxOut), .Zq(Zq),
    .HIq(HIq), .LOq(LOq), .PCq(PCq), .IRq(IRq), .MARq(MARq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    clr = 0; r_in = '0; r_out = '0;
    HIin = 0; LOin = 0; HIout = 0; LOout = 0; Zin = 0; Zhighout = 0; Zlowout = 0;
    PCin = 0; PCout = 0; incPC = 0; IRin = 0; MARin = 0; MDRin = 0; MDRout = 0;
    Read = 0; InPortin = 0; InPortout = 0; Cin = 0; Cout = 0; Yin = 0; opcode = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle(); Read = 1; Mdatain = v; MDRin = 1; tick(); idle();
  endtask

  task automatic load_r(input int n, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; r_in[n] = 1; tick(); idle();
  endtask

  task automatic run_alu(input int a, input int b, input logic [4:0] op);
    idle(); r_out[a] = 1; Yin = 1; tick();
    idle(); r_out[b] = 1; opcode = op; Zin = 1; tick(); idle();
  endtask

  task automatic add_vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] z);
    vec_t v;
    v.tag = tag; v.op = op; v.a = a; v.b = b; v.z = z;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    Mdatain = '0; InPort_data = '0;
    idle(); clr = 1; tick(); tick(); idle();
    sb_push("rst_z", 64'd0);   sb_check(Zq);
    sb_push("rst_pc", 64'd0);  sb_check({32'd0, PCq});
    sb_push("rst_hi", 64'd0);  sb_check({32'd0, HIq});
    sb_push("rst_bus", 64'd0); sb_check({32'd0, BusMuxOut});

    // Bus idle with registers holding data, then priority ordering.
    load_r(5, 32'h0000_0055);
    load_r(0, 32'h0000_0011);
    load_mdr(32'h0000_00AA); MDRout = 1; PCin = 1; tick(); idle();
    load_mdr(32'h0000_0077);
    sb_push("bus_idle", 64'd0); sb_check({32'd0, BusMuxOut});
    r_out[5] = 1; PCout = 1; MDRout = 1; #1;
    sb_push("bus_r5_over_pc", 64'h55); sb_check({32'd0, BusMuxOut});
    r_out[0] = 1; #1;
    sb_push("bus_r0_over_r5", 64'h11); sb_check({32'd0, BusMuxOut});
    r_out = '0; #1;
    sb_push("bus_pc_over_mdr", 64'hAA); sb_check({32'd0, BusMuxOut});
    idle();

    add_vec("add_wrap", 5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0);
    add_vec("sub_neg",  5'b00100, 32'h0000_0005, 32'h0000_0007, 64'h0000_0000_FFFF_FFFE);
    add_vec("and",      5'b00101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0);
    add_vec("or",       5'b00110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_FFF0_FFF0);
    add_vec("shra",     5'b01010, 32'h8000_0000, 32'h0000_0004, 64'h0000_0000_F800_0000);
    add_vec("ror1",     5'b00111, 32'h0000_0001, 32'h0000_0001, 64'h0000_0000_8000_0000);
    add_vec("ror0",     5'b00111, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_1234_5678);
    add_vec("rol4",     5'b01000, 32'h8000_0001, 32'h0000_0004, 64'h0000_0000_0000_0018);
    add_vec("shr31",    5'b01001, 32'h8000_0000, 32'h0000_001F, 64'h0000_0000_0000_0001);
    add_vec("shl_mask", 5'b01011, 32'h0000_0003, 32'h0000_0024, 64'h0000_0000_0000_0030);
    add_vec("neg",      5'b10001, 32'h0000_007B, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF);
    add_vec("not",      5'b10010, 32'h0000_007B, 32'h0000_FFFF, 64'h0000_0000_FFFF_0000);
    add_vec("div_neg",  5'b01111, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
    add_vec("div_zero", 5'b01111, 32'h0000_0007, 32'h0000_0000, 64'h0000_0007_0000_0000);
    add_vec("div_ovf",  5'b01111, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    add_vec("mul_spec", 5'b10000, 32'h0001_0000, 32'hFFFF_0000, 64'hFFFF_FFFF_0000_0000);
    add_vec("mul_neg",  5'b10000, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    add_vec("bad_op",   5'b00000, 32'h1234_5678, 32'h0000_0001, 64'h0);

    foreach (vecs[i]) begin
      load_r(2, vecs[i].a);
      load_r(3, vecs[i].b);
      sb_push(vecs[i].tag, vecs[i].z);
      run_alu(2, 3, vecs[i].op);
      sb_check(Zq);
    end

    // Full divide sequence through LO/HI.
    load_r(2, 32'd16);
    load_r(3, 32'hFFFF_FFFE);
    run_alu(2, 3, 5'b01111);
    Zlowout = 1; LOin = 1; tick(); idle();
    Zhighout = 1; HIin = 1; tick(); idle();
    sb_push("div_lo", 64'h0000_0000_FFFF_FFF8); sb_check({32'd0, LOq});
    sb_push("div_hi", 64'd0);                   sb_check({32'd0, HIq});

    // incPC overrides a live opcode.
    load_mdr(32'd7); MDRout = 1; PCin = 1; tick(); idle();
    PCout = 1; incPC = 1; opcode = 5'b00100; Zin = 1; tick(); idle();
    sb_push("incpc_z", 64'd8); sb_check(Zq);
    Zlowout = 1; PCin = 1; tick(); idle();
    sb_push("incpc_pc", 64'd8); sb_check({32'd0, PCq});

    // IR/MAR load and InPort/C paths.
    load_mdr(32'hDEAD_BEEF); MDRout = 1; IRin = 1; MARin = 1; Cin = 1; tick(); idle();
    sb_push("ir", 64'hDEAD_BEEF);  sb_check({32'd0, IRq});
    sb_push("mar", 64'hDEAD_BEEF); sb_check({32'd0, MARq});
    InPort_data = 32'h0000_1234; InPortin = 1; tick(); idle();
    InPortout = 1; #1;
    sb_push("inport_bus", 64'h1234); sb_check({32'd0, BusMuxOut});
    idle(); Cout = 1; #1;
    sb_push("c_bus", 64'hDEAD_BEEF); sb_check({32'd0, BusMuxOut});
    idle();

    // clr beats every enable, including a same-cycle PC load.
    load_mdr(32'h0000_0099);
    MDRout = 1; PCin = 1; LOin = 1; clr = 1; tick(); idle();
    sb_push("clr_z", 64'd0);   sb_check(Zq);
    sb_push("clr_pc", 64'd0);  sb_check({32'd0, PCq});
    sb_push("clr_lo", 64'd0);  sb_check({32'd0, LOq});
    sb_push("clr_hi", 64'd0);  sb_check({32'd0, HIq});
    sb_push("clr_ir", 64'd0);  sb_check({32'd0, IRq});
    sb_push("clr_mar", 64'd0); sb_check({32'd0, MARq});
    InPortout = 1; Cout = 1; MDRout = 1; r_out[5] = 1; #1;
    sb_push("clr_bus", 64'd0); sb_check({32'd0, BusMuxOut});
    idle();

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
